// File: rtl/sync_width_fifo.sv
// sync_width_fifo: single-clock FIFO that unpacks RATIO-wide write words into read words
// Ports: clk, rst (async, active-high); di/we write side; re/dout/valid read side;
//   empty_flag/aempty/full_flag/afull status; overflow/underflow/wr_success one-cycle pulses;
//   rdusedw/wrusedw occupancy in read/write words.
// Define SYNC_WIDTH_FIFO_OUTREG_EN to add an output register after the read mux (normal mode only).
module sync_width_fifo #(
  parameter int DATA_WIDTH_R = 8,
  parameter int RATIO = 2,
  parameter int ADDR_WIDTH_W = 10,
  parameter int AL_FULL_NUM = 1021,
  parameter int AL_EMPTY_NUM = 2,
  parameter int LSB_FIRST = 1,
  parameter int SHOW_AHEAD_EN = 0,
  parameter logic [DATA_WIDTH_R-1:0] DOUT_INITVAL = '0,
  localparam int LR = $clog2(RATIO),
  localparam int DATA_WIDTH_W = DATA_WIDTH_R * RATIO,
  localparam int ADDR_WIDTH_R = ADDR_WIDTH_W + LR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH_W-1:0] di,
  input  logic                    we,
  input  logic                    re,
  output logic [DATA_WIDTH_R-1:0] dout,
  output logic                    valid,
  output logic                    empty_flag,
  output logic                    aempty,
  output logic                    full_flag,
  output logic                    afull,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    wr_success,
  output logic [ADDR_WIDTH_R:0]   rdusedw,
  output logic [ADDR_WIDTH_W:0]   wrusedw
);
  localparam int DEPTH_W = 1 << ADDR_WIDTH_W;
  logic [DATA_WIDTH_W-1:0] mem [DEPTH_W];
  logic [ADDR_WIDTH_W:0] wp;
  logic [ADDR_WIDTH_R:0] rp;
  logic [DATA_WIDTH_W-1:0] rd_word;
  logic [31:0] lane;
  logic [DATA_WIDTH_R-1:0] head;
  logic wr_ok, rd_ok;
  // Occupancy comes straight from the registered pointers, so it reflects the previous edge.
  assign rdusedw = ((ADDR_WIDTH_R+1)'(wp) << LR) - rp;
  // Dropping the lane bits of rp counts a partially drained word as still occupied.
  assign wrusedw = wp - rp[ADDR_WIDTH_R:LR];
  assign full_flag = wrusedw == (ADDR_WIDTH_W+1)'(DEPTH_W);
  assign afull = wrusedw >= (ADDR_WIDTH_W+1)'(AL_FULL_NUM);
  assign empty_flag = rdusedw == '0;
  assign aempty = rdusedw <= (ADDR_WIDTH_R+1)'(AL_EMPTY_NUM);
  assign wr_ok = we && !full_flag;
  assign rd_ok = re && !empty_flag;
  assign rd_word = mem[rp[ADDR_WIDTH_R-1:LR]];
  assign lane = LSB_FIRST != 0 ? 32'(rp) & 32'(RATIO-1) : 32'(RATIO-1) - (32'(rp) & 32'(RATIO-1));
  assign head = rd_word[lane*DATA_WIDTH_R +: DATA_WIDTH_R];
  always_ff @(posedge clk)
    if (wr_ok) mem[wp[ADDR_WIDTH_W-1:0]] <= di;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      wr_success <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp <= wp + (ADDR_WIDTH_W+1)'(wr_ok);
      rp <= rp + (ADDR_WIDTH_R+1)'(rd_ok);
      wr_success <= wr_ok;
      overflow <= we && full_flag;
      underflow <= re && empty_flag;
    end
  generate
    if (SHOW_AHEAD_EN != 0) begin : g_sa
      // Last popped word is shown while empty so dout holds instead of exposing stale memory.
      logic [DATA_WIDTH_R-1:0] last;
      always_ff @(posedge clk or posedge rst)
        if (rst) last <= DOUT_INITVAL;
        else if (rd_ok) last <= head;
      assign dout = empty_flag ? last : head;
      assign valid = !empty_flag;
    end else begin : g_nm
      logic [DATA_WIDTH_R-1:0] d;
      logic v;
`ifdef SYNC_WIDTH_FIFO_OUTREG_EN
      logic [DATA_WIDTH_R-1:0] d1;
      logic v1;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          d1 <= DOUT_INITVAL;
          v1 <= 1'b0;
          d <= DOUT_INITVAL;
          v <= 1'b0;
        end else begin
          v1 <= rd_ok;
          if (rd_ok) d1 <= head;
          v <= v1;
          if (v1) d <= d1;
        end
`else
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          d <= DOUT_INITVAL;
          v <= 1'b0;
        end else begin
          v <= rd_ok;
          if (rd_ok) d <= head;
        end
`endif
      assign dout = d;
      assign valid = v;
    end
  endgenerate
endmodule

// File: tb/tb_sync_width_fifo.sv
// tb_sync_width_fifo: directed checks of sync_width_fifo in normal and show-ahead configurations
module tb_sync_width_fifo;
  logic clk, rst;
  logic [15:0] di_a;
  logic we_a, re_a;
  logic [7:0] dout_a, dout_b;
  logic valid_a, empty_a, aempty_a, full_a, afull_a, ovf_a, udf_a, wrs_a;
  logic valid_b, empty_b, aempty_b, full_b, afull_b, ovf_b, udf_b, wrs_b;
  logic [5:0] rdu_a, rdu_b;
  logic [4:0] wru_a, wru_b;
  logic [31:0] di_c;
  logic we_c, re_c;
  logic [7:0] dout_c;
  logic valid_c, empty_c, aempty_c, full_c, afull_c, ovf_c, udf_c, wrs_c;
  logic [5:0] rdu_c;
  logic [3:0] wru_c;
  int n_vec, n_bad;

  sync_width_fifo #(.DATA_WIDTH_R(8), .RATIO(2), .ADDR_WIDTH_W(4), .AL_FULL_NUM(14), .AL_EMPTY_NUM(2),
    .LSB_FIRST(1), .SHOW_AHEAD_EN(0), .DOUT_INITVAL(8'h5A)) dut_a (
    .clk(clk), .rst(rst), .di(di_a), .we(we_a), .re(re_a), .dout(dout_a), .valid(valid_a),
    .empty_flag(empty_a), .aempty(aempty_a), .full_flag(full_a), .afull(afull_a),
    .overflow(ovf_a), .underflow(udf_a), .wr_success(wrs_a), .rdusedw(rdu_a), .wrusedw(wru_a));

  sync_width_fifo #(.DATA_WIDTH_R(8), .RATIO(2), .ADDR_WIDTH_W(4), .AL_FULL_NUM(14), .AL_EMPTY_NUM(2),
    .LSB_FIRST(0), .SHOW_AHEAD_EN(0), .DOUT_INITVAL(8'h00)) dut_b (
    .clk(clk), .rst(rst), .di(di_a), .we(we_a), .re(re_a), .dout(dout_b), .valid(valid_b),
    .empty_flag(empty_b), .aempty(aempty_b), .full_flag(full_b), .afull(afull_b),
    .overflow(ovf_b), .underflow(udf_b), .wr_success(wrs_b), .rdusedw(rdu_b), .wrusedw(wru_b));

  sync_width_fifo #(.DATA_WIDTH_R(8), .RATIO(4), .ADDR_WIDTH_W(3), .AL_FULL_NUM(7), .AL_EMPTY_NUM(2),
    .LSB_FIRST(1), .SHOW_AHEAD_EN(1), .DOUT_INITVAL(8'h00)) dut_c (
    .clk(clk), .rst(rst), .di(di_c), .we(we_c), .re(re_c), .dout(dout_c), .valid(valid_c),
    .empty_flag(empty_c), .aempty(aempty_c), .full_flag(full_c), .afull(afull_c),
    .overflow(ovf_c), .underflow(udf_c), .wr_success(wrs_c), .rdusedw(rdu_c), .wrusedw(wru_c));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] expb;
  int popped, pushed, sz;
  bit wa, ra, full_m, empty_m;

  initial begin
    clk = 0; rst = 0; n_vec = 0; n_bad = 0;
    di_a = '0; we_a = 0; re_a = 0; di_c = '0; we_c = 0; re_c = 0;
    #1 rst = 1;
    #1;
    chk("rst_empty", empty_a, 1); chk("rst_aempty", aempty_a, 1); chk("rst_full", full_a, 0);
    chk("rst_afull", afull_a, 0); chk("rst_valid", valid_a, 0); chk("rst_dout", dout_a, 8'h5A);
    chk("rst_rdu", rdu_a, 0); chk("rst_wru", wru_a, 0); chk("rst_pulses", {ovf_a, udf_a, wrs_a}, 0);
    tick;
    rst = 0;
    // unpack order
    di_a = 16'hA1B2; we_a = 1;
    tick;
    we_a = 0; re_a = 1;
    chk("wr_success", wrs_a, 1); chk("wr_empty", empty_a, 0); chk("wr_rdu", rdu_a, 2); chk("wr_wru", wru_a, 1);
    tick;
    chk("lsb_first0", dout_a, 8'hB2); chk("lsb_valid0", valid_a, 1); chk("msb_first0", dout_b, 8'hA1);
    tick;
    chk("lsb_first1", dout_a, 8'hA1); chk("lsb_valid1", valid_a, 1); chk("msb_first1", dout_b, 8'hB2);
    chk("drained_empty", empty_a, 1); chk("partial_wru", wru_a, 0);
    tick;
    re_a = 0;
    chk("underflow", udf_a, 1); chk("udf_novalid", valid_a, 0); chk("udf_hold", dout_a, 8'hA1);
    // async reset mid-stream with 5 words stored
    for (int i = 0; i < 5; i++) begin
      di_a = {8'(8'hC0 + i), 8'(8'h40 + i)}; we_a = 1;
      tick;
    end
    we_a = 0; re_a = 1;
    tick;
    re_a = 0;
    chk("pre_rst_dout", dout_a, 8'h40); chk("pre_rst_rdu", rdu_a, 9);
    #3 rst = 1;
    #1;
    chk("mid_rst_empty", empty_a, 1); chk("mid_rst_rdu", rdu_a, 0); chk("mid_rst_wru", wru_a, 0);
    chk("mid_rst_dout", dout_a, 8'h5A); chk("mid_rst_valid", valid_a, 0);
    @(posedge clk);
    #1 rst = 0; re_a = 1;
    tick;
    re_a = 0;
    chk("post_rst_udf", udf_a, 1); chk("post_rst_valid", valid_a, 0);
    // fill to full
    for (int i = 0; i < 16; i++) begin
      di_a = {8'(8'h80 + i), 8'(i)}; we_a = 1;
      tick;
    end
    chk("full_flag", full_a, 1); chk("full_wru", wru_a, 16); chk("full_rdu", rdu_a, 32); chk("full_afull", afull_a, 1);
    tick;
    we_a = 0; re_a = 1;
    chk("overflow", ovf_a, 1); chk("ovf_nowrs", wrs_a, 0); chk("ovf_rdu", rdu_a, 32);
    tick;
    re_a = 0;
    chk("full_rd_dout", dout_a, 8'h00); chk("full_rd_wru", wru_a, 16); chk("full_rd_rdu", rdu_a, 31);
    chk("full_rd_full", full_a, 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    // random-gap traffic through several pointer wraps against a byte queue model
    popped = 0; pushed = 0;
    for (int cyc = 0; cyc < 3000 && popped < 96; cyc++) begin
      sz = q.size();
      full_m = ((sz + 1) / 2) == 16;
      empty_m = sz == 0;
      we_a = (pushed < 48) && ($urandom_range(0, 9) < (cyc < 60 ? 9 : 5));
      re_a = $urandom_range(0, 9) < (cyc < 60 ? 2 : 8);
      di_a = 16'($urandom);
      wa = we_a && !full_m;
      ra = re_a && !empty_m;
      if (ra) expb = q.pop_front();
      if (wa) begin
        q.push_back(di_a[7:0]);
        q.push_back(di_a[15:8]);
        pushed++;
      end
      tick;
      if (ra) begin
        chk("wrap_dout", dout_a, expb);
        popped++;
      end
      sz = q.size();
      chk("wrap_valid", valid_a, ra); chk("wrap_wrs", wrs_a, wa);
      chk("wrap_ovf", ovf_a, we_a && full_m); chk("wrap_udf", udf_a, re_a && empty_m);
      chk("wrap_rdu", rdu_a, sz); chk("wrap_wru", wru_a, (sz + 1) / 2);
      chk("wrap_aempty", aempty_a, sz <= 2); chk("wrap_afull", afull_a, ((sz + 1) / 2) >= 14);
      chk("wrap_full", full_a, ((sz + 1) / 2) == 16); chk("wrap_empty", empty_a, sz == 0);
    end
    we_a = 0; re_a = 0;
    chk("wrap_pops", popped, 96);
    // show-ahead, RATIO=4
    di_c = 32'h04030201; we_c = 1;
    tick;
    we_c = 0;
    chk("sa_dout0", dout_c, 8'h01); chk("sa_valid", valid_c, 1); chk("sa_rdu", rdu_c, 4); chk("sa_aempty", aempty_c, 0);
    re_c = 1;
    tick;
    chk("sa_dout1", dout_c, 8'h02);
    tick;
    chk("sa_dout2", dout_c, 8'h03);
    tick;
    chk("sa_dout3", dout_c, 8'h04);
    tick;
    re_c = 0;
    chk("sa_empty", empty_c, 1); chk("sa_novalid", valid_c, 0); chk("sa_noudf", udf_c, 0);
    // simultaneous read and write
    di_c = 32'h14131211; we_c = 1;
    tick;
    chk("sim_pre_rdu", rdu_c, 4);
    di_c = 32'h24232221; re_c = 1;
    tick;
    chk("sim_rdu", rdu_c, 7); chk("sim_wrs", wrs_c, 1); chk("sim_dout", dout_c, 8'h12); chk("sim_wru", wru_c, 2);
    re_c = 0;
    for (int i = 0; i < 6; i++) begin
      di_c = 32'h55555555; we_c = 1;
      tick;
    end
    chk("c_full", full_c, 1); chk("c_full_rdu", rdu_c, 31);
    re_c = 1;
    tick;
    we_c = 0; re_c = 0;
    chk("full_sim_ovf", ovf_c, 1); chk("full_sim_wrs", wrs_c, 0); chk("full_sim_rdu", rdu_c, 30);
    chk("full_sim_wru", wru_c, 8); chk("full_sim_dout", dout_c, 8'h13);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
